// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the byte-serial memory controller:
//   - DATA_W / ADDR_W : 32-bit data and address widths
//   - CNT_W           : width of the per-transaction byte/step counter
//   - state_t         : controller FSM encoding (IDLE, READ, WRITE, DONE)
//   - LEN_*           : mem_len size codes (2'b11 is decoded as a word)
//   - len_to_bytes()  : size code -> number of bytes moved
//   - merge_byte()    : drops a RAM byte into its lane of the read buffer
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Size code to byte count; the unused code 2'b11 falls through to a word.
  function automatic logic [CNT_W-1:0] len_to_bytes(input logic [1:0] len);
    logic [CNT_W-1:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // A read step value of k+1 means ram_din currently holds byte k, so the
  // step number selects lane k. Step 0 carries no valid RAM data.
  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                   input logic [CNT_W-1:0]  step,
                                                   input logic [7:0]        data);
    logic [DATA_W-1:0] r;
    r = word;
    case (step)
      3'd1:    r[7:0]   = data;
      3'd2:    r[15:8]  = data;
      3'd3:    r[23:16] = data;
      3'd4:    r[31:24] = data;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates an instruction-fetch port and a load/store port onto a single
// byte-wide RAM with one cycle of read latency. Loads/stores and fetches are
// serialised one byte per cycle, little-endian, addresses wrapping at 32 bits.
// The load/store port has fixed priority over fetch. All outputs registered.
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-low reset
//   if_req     : fetch request (level, held until if_done)
//   if_addr    : fetch byte address (always a 4-byte read)
//   if_flush   : pipeline flush, only acts when FETCH_ABORT_EN is defined
//   if_done    : one-cycle pulse, if_inst valid
//   if_inst    : fetched word
//   mem_req    : load/store request (level, held until mem_done)
//   mem_we     : 1 = store, 0 = load
//   mem_len    : 00 byte, 01 half, 10/11 word
//   mem_addr   : load/store byte address
//   mem_wdata  : store data, byte 0 in bits [7:0]
//   mem_done   : one-cycle pulse, load/store complete
//   mem_rdata  : zero-extended load data
//   ram_a      : RAM byte address (holds last value when idle)
//   ram_dout   : RAM write data (0 when not writing)
//   ram_wr     : RAM write strobe
//   ram_din    : RAM read data, valid the cycle after ram_a
//   busy       : high whenever the controller is not IDLE
//
// Build option:
//   FETCH_ABORT_EN : when defined, if_flush during a fetch read abandons the
//                    fetch (back to IDLE next cycle, no if_done).
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_bytes;
  logic [ADDR_W-1:0] base;
  logic [23:0]       wdata_q;
  logic [DATA_W-1:0] rd_buf;
  logic              is_fetch;
  logic [DATA_W-1:0] rd_next;

`ifndef FETCH_ABORT_EN
  // Flush has no function in this build; tie it off explicitly.
  logic unused_flush;
  assign unused_flush = if_flush;
`endif

  // Read buffer with the byte currently on ram_din merged into its lane.
  always_comb begin
    rd_next = merge_byte(rd_buf, cnt, ram_din);
  end

  // Controller FSM. The transaction (address, size, store data, requester)
  // is latched at acceptance so later changes on the request ports have no
  // effect. In READ the counter runs 0..n: step k drives address k (k < n)
  // and captures byte k-1 (k >= 1), because RAM data lags the address by one
  // cycle. In WRITE step k drives address and data for byte k in the same
  // cycle. DONE lasts exactly one cycle and ignores all requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      n_bytes   <= '0;
      base      <= '0;
      wdata_q   <= '0;
      rd_buf    <= '0;
      is_fetch  <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          ram_wr   <= 1'b0;
          ram_dout <= '0;
          cnt      <= '0;
          if (mem_req) begin
            state    <= mem_we ? ST_WRITE : ST_READ;
            busy     <= 1'b1;
            is_fetch <= 1'b0;
            base     <= mem_addr;
            n_bytes  <= len_to_bytes(mem_len);
            wdata_q  <= mem_wdata[31:8];
            rd_buf   <= '0;
            ram_a    <= mem_addr;
            ram_wr   <= mem_we;
            ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
          end else if (if_req) begin
            state    <= ST_READ;
            busy     <= 1'b1;
            is_fetch <= 1'b1;
            base     <= if_addr;
            n_bytes  <= 3'd4;
            rd_buf   <= '0;
            ram_a    <= if_addr;
          end
        end

        ST_READ: begin
`ifdef FETCH_ABORT_EN
          if (is_fetch && if_flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else
`endif
          begin
            if (cnt != '0) begin
              rd_buf <= rd_next;
            end
            if (cnt == n_bytes) begin
              state <= ST_DONE;
              if (is_fetch) begin
                if_inst <= rd_next;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= rd_next;
                mem_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if ((cnt + 3'd1) < n_bytes) begin
                ram_a <= base + {29'b0, cnt + 3'd1};
              end
            end
          end
        end

        ST_WRITE: begin
          if (cnt == n_bytes - 3'd1) begin
            state    <= ST_DONE;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            ram_a    <= base + {29'b0, cnt + 3'd1};
            ram_dout <= wdata_q[7:0];
            wdata_q  <= {8'h00, wdata_q[23:8]};
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl with a byte-wide RAM model (one cycle read
// latency, 64 KiB indexed by the low 16 address bits). Expected values are
// hand-computed constants. Honours FETCH_ABORT_EN for the flush scenario.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        busy;

  bit [7:0] mem [65536];

  int checks = 0;
  int fails  = 0;

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_inst   (if_inst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model: power-on contents loaded while reset is low, then
  // synchronous byte writes and one-cycle-latency reads.
  always @(posedge clk) begin
    if (!rst) begin
      mem[16'h1000] <= 8'h13;
      mem[16'h1001] <= 8'h05;
      mem[16'h1002] <= 8'h00;
      mem[16'h1003] <= 8'h00;
      mem[16'h0020] <= 8'hFF;
      mem[16'hFFFE] <= 8'h11;
      mem[16'hFFFF] <= 8'h22;
      mem[16'h0000] <= 8'h33;
      mem[16'h0001] <= 8'h44;
    end else if (ram_wr) begin
      mem[ram_a[15:0]] <= ram_dout;
    end
    ram_din <= mem[ram_a[15:0]];
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic        f_req,
                               input logic [31:0] f_addr,
                               input logic        m_req,
                               input logic        m_we,
                               input logic [1:0]  m_len,
                               input logic [31:0] m_addr,
                               input logic [31:0] m_wdata);
    if_req    = f_req;
    if_addr   = f_addr;
    mem_req   = m_req;
    mem_we    = m_we;
    mem_len   = m_len;
    mem_addr  = m_addr;
    mem_wdata = m_wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    if_flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy",      {31'b0, busy},     32'h0);
    checkOutput("rst_ram_wr",    {31'b0, ram_wr},   32'h0);
    checkOutput("rst_ram_a",     ram_a,             32'h0);
    checkOutput("rst_ram_dout",  {24'b0, ram_dout}, 32'h0);
    checkOutput("rst_if_done",   {31'b0, if_done},  32'h0);
    checkOutput("rst_mem_done",  {31'b0, mem_done}, 32'h0);
    checkOutput("rst_if_inst",   if_inst,           32'h0);
    checkOutput("rst_mem_rdata", mem_rdata,         32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b1;

    // Fetch of 0x1000; address port changes after acceptance must not matter.
    $display("[TB] fetch 0x00001000");
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("f_idle_busy", {31'b0, busy}, 32'h0);
    nextCycle();
    checkOutput("f_a0",    ram_a,             32'h0000_1000);
    checkOutput("f_busy",  {31'b0, busy},     32'h1);
    checkOutput("f_no_wr", {31'b0, ram_wr},   32'h0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    checkOutput("f_a1", ram_a, 32'h0000_1001);
    nextCycle();
    checkOutput("f_a2", ram_a, 32'h0000_1002);
    nextCycle();
    checkOutput("f_a3", ram_a, 32'h0000_1003);
    nextCycle();
    checkOutput("f_done_early", {31'b0, if_done}, 32'h0);
    nextCycle();
    checkOutput("f_done", {31'b0, if_done}, 32'h1);
    checkOutput("f_inst", if_inst,          32'h0000_0513);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    checkOutput("f_done_pulse", {31'b0, if_done}, 32'h0);
    checkOutput("f_idle",       {31'b0, busy},    32'h0);
    checkOutput("f_inst_hold",  if_inst,          32'h0000_0513);

    // Simultaneous fetch and byte load: load wins, fetch waits until after DONE.
    $display("[TB] arbitration");
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0);
    nextCycle();
    checkOutput("arb_a", ram_a, 32'h0000_0020);
    nextCycle();
    checkOutput("arb_done_early", {31'b0, mem_done}, 32'h0);
    nextCycle();
    checkOutput("arb_mem_done", {31'b0, mem_done}, 32'h1);
    checkOutput("arb_rdata",    mem_rdata,         32'h0000_00FF);
    checkOutput("arb_no_if",    {31'b0, if_done},  32'h0);
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    checkOutput("arb_idle", {31'b0, busy}, 32'h0);
    nextCycle();
    checkOutput("arb_f_busy", {31'b0, busy}, 32'h1);
    checkOutput("arb_f_a0",   ram_a,         32'h0000_1000);
    for (int i = 0; i < 5; i++) nextCycle();
    checkOutput("arb_f_done",     {31'b0, if_done}, 32'h1);
    checkOutput("arb_f_inst",     if_inst,          32'h0000_0513);
    checkOutput("arb_rdata_hold", mem_rdata,        32'h0000_00FF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();

    // Half-word store; upper store data bytes must not reach the RAM.
    $display("[TB] store half 0xABCD to 0x30");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h0000_0030, 32'h1234_ABCD);
    nextCycle();
    checkOutput("st_wr0", {31'b0, ram_wr},   32'h1);
    checkOutput("st_a0",  ram_a,             32'h0000_0030);
    checkOutput("st_d0",  {24'b0, ram_dout}, 32'h0000_00CD);
    nextCycle();
    checkOutput("st_wr1",   {31'b0, ram_wr},   32'h1);
    checkOutput("st_a1",    ram_a,             32'h0000_0031);
    checkOutput("st_d1",    {24'b0, ram_dout}, 32'h0000_00AB);
    checkOutput("st_early", {31'b0, mem_done}, 32'h0);
    nextCycle();
    checkOutput("st_done",       {31'b0, mem_done}, 32'h1);
    checkOutput("st_wr_off",     {31'b0, ram_wr},   32'h0);
    checkOutput("st_dout_zero",  {24'b0, ram_dout}, 32'h0);
    checkOutput("st_rdata_hold", mem_rdata,         32'h0000_00FF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    checkOutput("st_idle",  {31'b0, busy},   32'h0);
    checkOutput("st_m30",   {24'b0, mem[16'h0030]}, 32'h0000_00CD);
    checkOutput("st_m31",   {24'b0, mem[16'h0031]}, 32'h0000_00AB);
    checkOutput("st_m32",   {24'b0, mem[16'h0032]}, 32'h0);

    // Word load across the top of the address space, size code 11.
    $display("[TB] word load at 0xFFFFFFFE");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0);
    nextCycle();
    checkOutput("wrap_a0", ram_a, 32'hFFFF_FFFE);
    nextCycle();
    checkOutput("wrap_a1", ram_a, 32'hFFFF_FFFF);
    nextCycle();
    checkOutput("wrap_a2", ram_a, 32'h0000_0000);
    nextCycle();
    checkOutput("wrap_a3", ram_a, 32'h0000_0001);
    nextCycle();
    checkOutput("wrap_early", {31'b0, mem_done}, 32'h0);
    nextCycle();
    checkOutput("wrap_done",  {31'b0, mem_done}, 32'h1);
    checkOutput("wrap_rdata", mem_rdata,         32'h4433_2211);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();

    // Reset asserted while byte 2 of a word store is on the bus.
    $display("[TB] reset during store");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'h0102_0304);
    nextCycle();
    checkOutput("rw_d0", {24'b0, ram_dout}, 32'h0000_0004);
    nextCycle();
    nextCycle();
    checkOutput("rw_a2",  ram_a,             32'h0000_0042);
    checkOutput("rw_wr2", {31'b0, ram_wr},   32'h1);
    checkOutput("rw_d2",  {24'b0, ram_dout}, 32'h0000_0002);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    checkOutput("rw_wr_off", {31'b0, ram_wr},   32'h0);
    checkOutput("rw_busy",   {31'b0, busy},     32'h0);
    checkOutput("rw_a",      ram_a,             32'h0);
    checkOutput("rw_dout",   {24'b0, ram_dout}, 32'h0);
    checkOutput("rw_rdata",  mem_rdata,         32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    checkOutput("rw_rel_done", {31'b0, mem_done}, 32'h0);
    nextCycle();
    checkOutput("rw_post_done", {31'b0, mem_done}, 32'h0);
    checkOutput("rw_post_busy", {31'b0, busy},     32'h0);
    nextCycle();
    checkOutput("rw_post_done2", {31'b0, mem_done}, 32'h0);
    checkOutput("rw_m41", {24'b0, mem[16'h0041]}, 32'h0000_0003);
    checkOutput("rw_m42", {24'b0, mem[16'h0042]}, 32'h0);

    // Flush two cycles after fetch acceptance.
    $display("[TB] fetch flush");
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    if_flush = 1'b1;
    nextCycle();
    if_flush = 1'b0;
`ifdef FETCH_ABORT_EN
    checkOutput("fl_busy", {31'b0, busy}, 32'h0);
    checkOutput("fl_done", {31'b0, if_done}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("fl_no_done", {31'b0, if_done}, 32'h0);
    checkOutput("fl_inst",    if_inst,          32'h0);
    checkOutput("fl_idle",    {31'b0, busy},    32'h0);
`else
    checkOutput("fl_busy", {31'b0, busy}, 32'h1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("fl_done", {31'b0, if_done}, 32'h1);
    checkOutput("fl_inst", if_inst,          32'h0000_0513);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
`endif
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: if_req  in  1  fetch request, level, held until if_done.
REQ-004 SHALL have: if_addr  in  32  fetch byte address.
REQ-005 SHALL have: if_flush  in  1  branch flush from pipeline.
REQ-006 SHALL have: if_done  out  1  one-cycle pulse, if_inst valid.
REQ-007 SHALL have: if_inst  out  32  fetched word, little-endian.
REQ-008 SHALL have: mem_req  in  1  load/store request, level, held until mem_done.
REQ-009 SHALL have: mem_we, mem_len, mem_addr, mem_wdata  in  1/2/32/32  write flag, size (00 byte, 01 half, 10 word), address, store data.
REQ-010 SHALL have: mem_done  out  1  one-cycle pulse; mem_rdata  out  32  zero-extended load data.
REQ-011 SHALL have: ram_a  out  32, ram_dout  out  8, ram_wr  out  1, ram_din  in  8  byte-wide RAM port; ram_din in cycle t+1 holds byte addressed in cycle t.
REQ-012 SHALL have: busy  out  1  high in any non-IDLE state.

Function
REQ-013 SHALL implement states IDLE, READ, WRITE, DONE; all outputs registered.
REQ-014 SHALL, in IDLE, accept mem_req over if_req when both high (fixed priority to MEM); fetch is always 4-byte read.
REQ-015 SHALL, on accepting in cycle C, drive byte k address (base+k, 32-bit wrap) in cycle C+1+k, k=0..n-1, n=1/2/4.
REQ-016 SHALL, for reads, capture ram_din byte k in cycle C+2+k into bit lane 8k and pulse done in cycle C+n+2.
REQ-017 SHALL, for writes, drive ram_wr=1 with wdata byte k in cycle C+1+k and pulse done in cycle C+n+1; ram_wr=0 in all other cycles.
REQ-018 SHALL hold ram_a at last value and ram_dout at 0 when idle.
REQ-019 SHALL enter DONE for exactly the done cycle, ignore all requests there, return to IDLE next cycle.
REQ-020 SHALL hold if_inst/mem_rdata stable from done until next completion of the same requester.
REQ-021 SHALL treat mem_len=11 as word.
REQ-022 SHALL not sample requester inputs after acceptance; request data changes mid-transaction have no effect.

Reset
REQ-023 SHALL, while rst=0, asynchronously force state IDLE, ram_wr=0, ram_a=0, ram_dout=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0, busy=0, byte counter 0.
REQ-024 SHALL abort any transaction on reset mid-operation; no done pulse after release; first acceptance no earlier than first rising edge after release.

Configuration
REQ-025 SHALL support macro FETCH_ABORT_EN.
REQ-026 SHALL, with FETCH_ABORT_EN defined, on if_flush=1 during a fetch READ, go to IDLE next cycle without if_done; if_flush ignored otherwise.
REQ-027 SHALL, without FETCH_ABORT_EN, ignore if_flush; fetches always complete with if_done.

Structure
REQ-028 SHALL take state encoding, mem_len codes and 32-bit data/address width constants from the shared defines package.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHALL cover: fetch at 0x00001000, RAM bytes 13 05 00 00 -> ram_a 0x1000..0x1003 in C+1..C+4, if_done in C+6, if_inst=0x00000513.
REQ-031 SHALL cover: if_req and mem_req (load byte 0x20, byte 0xFF) same cycle -> load first, mem_rdata=0x000000FF at C+3, fetch accepted in cycle after DONE.
REQ-032 SHALL cover: store half 0xABCD to 0x30 -> ram_wr=1 with 0xCD@0x30, 0xAB@0x31, mem_done in C+3.
REQ-033 SHALL cover: word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-034 SHALL cover: rst low during write byte 2 -> ram_wr=0 immediately, no mem_done, IDLE after release.
REQ-035 SHALL cover: if_flush in cycle C+2 of fetch -> with FETCH_ABORT_EN IDLE at C+3, no if_done; without, if_done at C+6.
